// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int unsigned STAT_W = 16;

    // Wait counter must hold WAIT_CYCLES and be at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; read data is held until the next read enable.
module mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory side of the cache strobe interface: latch, wait WAIT_CYCLES, respond.
// Optional MEM_STAT_EN adds saturating read/write transaction counters.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy
`ifdef MEM_STAT_EN
    ,
    output logic [STAT_W-1:0] RdCount,
    output logic [STAT_W-1:0] WrCount
`endif
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic done_c;
    logic ram_we_c;
    logic ram_re_c;

    // Last wait edge: the array access and the move to RESP happen together.
    assign done_c   = (state == WAIT) && (cnt == '0);
    assign ram_we_c = done_c && (req_rw == MEM_WRITE);
    assign ram_re_c = done_c && (req_rw == MEM_READ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_rw   <= MEM_READ;
            req_addr <= '0;
            req_data <= '0;
            MReady   <= 1'b0;
            MBusy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MStrobe) begin
                        req_rw   <= MRW;
                        req_addr <= MAddr;
                        req_data <= MDataIn;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= WAIT;
                        MBusy    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= RESP;
                        MReady <= 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    MReady <= 1'b0;
                    MBusy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The array's read register is the MDataOut register.
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (req_addr),
        .wdata (req_data),
        .rdata (MDataOut)
    );

`ifdef MEM_STAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RdCount <= '0;
            WrCount <= '0;
        end else begin
            if (ram_re_c && (RdCount != '1)) begin
                RdCount <= RdCount + STAT_W'(1);
            end
            if (ram_we_c && (WrCount != '1)) begin
                WrCount <= WrCount + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    parameter int unsigned WC = 4;

    logic        clk;
    logic        reset;
    logic        MStrobe;
    logic        MRW;
    logic [7:0]  MAddr;
    logic [31:0] MDataIn;
    logic [31:0] MDataOut;
    logic        MReady;
    logic        MBusy;
`ifdef MEM_STAT_EN
    logic [15:0] RdCount;
    logic [15:0] WrCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MStrobe  (MStrobe),
        .MRW      (MRW),
        .MAddr    (MAddr),
        .MDataIn  (MDataIn),
        .MDataOut (MDataOut),
        .MReady   (MReady),
        .MBusy    (MBusy)
`ifdef MEM_STAT_EN
        ,
        .RdCount  (RdCount),
        .WrCount  (WrCount)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One complete transaction; entered and left #1 after a rising edge with the DUT idle.
    task automatic do_req(input logic rw, input logic [7:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic busy0, output logic tail);
        MStrobe = 1'b1;
        MRW     = rw;
        MAddr   = a;
        MDataIn = d;
        @(posedge clk); #1;
        MStrobe = 1'b0;
        busy0   = MBusy;
        lat     = -1;
        rd      = '0;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (MReady) begin
                lat = k;
                rd  = MDataOut;
            end
        end
        @(posedge clk); #1;
        tail = MReady | MBusy;
    endtask

    task automatic apply_reset();
        #3 reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        MStrobe = 1'b0;
        MRW     = 1'b0;
        MAddr   = '0;
        MDataIn = '0;
        #12;
        n_checks++;
        if (MReady !== 1'b0) begin n_fail++; $display("FAIL reset_mready got %b want 0", MReady); end
        n_checks++;
        if (MBusy !== 1'b0) begin n_fail++; $display("FAIL reset_mbusy got %b want 0", MBusy); end
        n_checks++;
        if (MDataOut !== 32'h0) begin n_fail++; $display("FAIL reset_mdataout got %h want 0", MDataOut); end
        #6 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic b0; logic tl;
        do_req(1'b1, 8'h10, 32'hDEADBEEF, lat, rd, b0, tl);
        n_checks++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL wr_busy_at_capture got %b want 1", b0); end
        n_checks++;
        if (lat != int'(WC) + 1) begin n_fail++; $display("FAIL wr_latency got %0d want %0d", lat, WC + 1); end
        n_checks++;
        if (tl !== 1'b0) begin n_fail++; $display("FAIL wr_idle_after got %b want 0", tl); end
        do_req(1'b0, 8'h10, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (lat != int'(WC) + 1) begin n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, WC + 1); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
        n_checks++;
        if (MDataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_held got %h want deadbeef", MDataOut); end
    endtask

    task automatic test_async_reset();
        MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h10;
        @(posedge clk); #1;
        MStrobe = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (MBusy !== 1'b0) begin n_fail++; $display("FAIL async_rst_mbusy got %b want 0", MBusy); end
        n_checks++;
        if (MReady !== 1'b0) begin n_fail++; $display("FAIL async_rst_mready got %b want 0", MReady); end
        n_checks++;
        if (MDataOut !== 32'h0) begin n_fail++; $display("FAIL async_rst_mdataout got %h want 0", MDataOut); end
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_strobe_held();
        int pulses = 0;
        MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h10; MDataIn = 32'h0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (MReady) pulses++;
        end
        MStrobe = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (MReady) pulses++;
        end
        n_checks++;
        if (pulses != (20 + int'(WC) + 2) / (int'(WC) + 3)) begin
            n_fail++; $display("FAIL held_pulses got %0d want %0d", pulses, (20 + WC + 2) / (WC + 3));
        end
        n_checks++;
        if (MDataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL held_data got %h want deadbeef", MDataOut); end
    endtask

    task automatic test_latched_inputs();
        int lat; logic [31:0] rd; logic b0; logic tl; logic seen;
        do_req(1'b1, 8'h21, 32'hA5A50021, lat, rd, b0, tl);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20; MDataIn = 32'h1;
        @(posedge clk); #1;
        MStrobe = 1'b0; MRW = 1'b0; MAddr = 8'h21; MDataIn = 32'hFFFFFFFF;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (MReady) seen = 1'b1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL latch_ready got %b want 1", seen); end
        do_req(1'b0, 8'h20, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL latch_target got %h want 00000001", rd); end
        do_req(1'b0, 8'h21, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (rd !== 32'hA5A50021) begin n_fail++; $display("FAIL latch_other got %h want a5a50021", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] rd; logic b0; logic tl; int ready_seen = 0;
        do_req(1'b1, 8'h30, 32'h00001234, lat, rd, b0, tl);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h30; MDataIn = 32'h55;
        @(posedge clk); #1;
        MStrobe = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #3 reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (MReady) ready_seen++;
        end
        n_checks++;
        if (ready_seen != 0) begin n_fail++; $display("FAIL abort_no_ready got %0d want 0", ready_seen); end
        do_req(1'b0, 8'h30, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (rd !== 32'h00001234) begin n_fail++; $display("FAIL abort_no_commit got %h want 00001234", rd); end
    endtask

    task automatic test_addr_bounds();
        int lat; logic [31:0] rd; logic b0; logic tl;
        do_req(1'b1, 8'hFF, 32'hFFFF0000, lat, rd, b0, tl);
        do_req(1'b1, 8'h00, 32'h0000FFFF, lat, rd, b0, tl);
        do_req(1'b0, 8'hFF, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (rd !== 32'hFFFF0000) begin n_fail++; $display("FAIL addr_ff got %h want ffff0000", rd); end
        do_req(1'b0, 8'h00, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (rd !== 32'h0000FFFF) begin n_fail++; $display("FAIL addr_00 got %h want 0000ffff", rd); end
    endtask

`ifdef MEM_STAT_EN
    task automatic test_stats();
        int lat; logic [31:0] rd; logic b0; logic tl;
        apply_reset();
        n_checks++;
        if (WrCount !== 16'd0 || RdCount !== 16'd0) begin
            n_fail++; $display("FAIL stats_reset got wr=%0d rd=%0d want 0 0", WrCount, RdCount);
        end
        do_req(1'b1, 8'h40, 32'h40, lat, rd, b0, tl);
        do_req(1'b1, 8'h41, 32'h41, lat, rd, b0, tl);
        do_req(1'b0, 8'h40, 32'h0, lat, rd, b0, tl);
        do_req(1'b1, 8'h42, 32'h42, lat, rd, b0, tl);
        do_req(1'b0, 8'h42, 32'h0, lat, rd, b0, tl);
        n_checks++;
        if (WrCount !== 16'd3) begin n_fail++; $display("FAIL stats_wr got %0d want 3", WrCount); end
        n_checks++;
        if (RdCount !== 16'd2) begin n_fail++; $display("FAIL stats_rd got %0d want 2", RdCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_async_reset();
        test_strobe_held();
        test_latched_inputs();
        test_reset_mid_write();
        test_addr_bounds();
`ifdef MEM_STAT_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
